// File: rtl/counter_sampler_pkg.sv
// Shared types and constants for the counter sampler and its sample FIFO.
// sample_t is the record at the default value width; the top builds the same layout at its own width.
package counter_sampler_pkg;

  localparam int SEQ_W    = 8;
  localparam int DROP_W   = 16;
  localparam int SAMPLE_W = 16;

  typedef struct packed {
    logic [SEQ_W-1:0]    seq;
    logic [SAMPLE_W-1:0] value;
    logic [SAMPLE_W-1:0] delta;
  } sample_t;

  // Occupancy needs one bit more than the pointer so that "full" is representable.
  function automatic int cnt_width(input int entries);
    return $clog2(entries) + 1;
  endfunction

endpackage

// File: rtl/sampler_fifo.sv
// Synchronous FIFO with a registered storage head and a zeroed head while empty.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module sampler_fifo
  import counter_sampler_pkg::*;
#(
  parameter int dwidth = 8,
  parameter int depth  = 4,
  parameter int cwidth = cnt_width(depth)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [dwidth-1:0] push_data,
  input  logic              pop,
  output logic [dwidth-1:0] head,
  output logic              empty,
  output logic              full,
  output logic [cwidth-1:0] count
);

  localparam int AW = $clog2(depth);

  logic [dwidth-1:0] mem [depth];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              push_ok;
  logic              pop_ok;

  assign empty   = (count == '0);
  assign full    = (count == cwidth'(depth));
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign head = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/counter_sampler.sv
// Periodically (or on SNAP) samples a counter bus, computes the modular delta and queues it.
// Optional drop counter (DROPS / DROPS_CLR) is built when SAMPLER_DROP_CNT_EN is defined.
module counter_sampler
  import counter_sampler_pkg::*;
#(
  parameter int width  = SAMPLE_W,
  parameter int period = 1000,
  parameter int depth  = 4,
  parameter int cwidth = cnt_width(depth)
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [width-1:0]  Q_IN,
  input  logic              ENABLE,
  input  logic              SNAP,
  output logic              OUT_VALID,
  input  logic              OUT_READY,
  output logic [width-1:0]  OUT_VALUE,
  output logic [width-1:0]  OUT_DELTA,
  output logic [SEQ_W-1:0]  OUT_SEQ,
`ifdef SAMPLER_DROP_CNT_EN
  output logic [DROP_W-1:0] DROPS,
  input  logic              DROPS_CLR,
`endif
  output logic [cwidth-1:0] COUNT
);

  localparam int TW = $clog2(period);

  typedef struct packed {
    logic [SEQ_W-1:0] seq;
    logic [width-1:0] value;
    logic [width-1:0] delta;
  } rec_t;

  logic [TW-1:0]    timer;
  logic [width-1:0] last;
  logic [SEQ_W-1:0] seq;
  logic             evt;
  logic             pop;
  logic             full;
  logic             empty;
  logic             drop;
  rec_t             rec_in;
  rec_t             rec_out;

  assign evt  = SNAP | (ENABLE & (timer == TW'(period - 1)));
  assign pop  = OUT_VALID & OUT_READY;
  assign drop = evt & full & ~pop;

  assign rec_in.seq   = seq;
  assign rec_in.value = Q_IN;
  assign rec_in.delta = Q_IN - last;

  // last and seq advance even when the FIFO drops the sample, so gaps show in OUT_SEQ
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      timer <= '0;
      last  <= '0;
      seq   <= '0;
    end else if (evt) begin
      timer <= '0;
      last  <= Q_IN;
      seq   <= seq + 1'b1;
    end else if (ENABLE) begin
      timer <= timer + 1'b1;
    end
  end

  sampler_fifo #(
    .dwidth ($bits(rec_t)),
    .depth  (depth),
    .cwidth (cwidth)
  ) u_fifo (
    .clk       (CLK),
    .rst       (RST),
    .push      (evt),
    .push_data (rec_in),
    .pop       (pop),
    .head      (rec_out),
    .empty     (empty),
    .full      (full),
    .count     (COUNT)
  );

  assign OUT_VALID = ~empty;
  assign OUT_VALUE = rec_out.value;
  assign OUT_DELTA = rec_out.delta;
  assign OUT_SEQ   = rec_out.seq;

`ifdef SAMPLER_DROP_CNT_EN
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      DROPS <= '0;
    end else if (DROPS_CLR) begin
      DROPS <= drop ? DROP_W'(1) : '0;
    end else if (drop && (DROPS != '1)) begin
      DROPS <= DROPS + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_counter_sampler.sv
// Directed bench for counter_sampler: two instances (period 4 and period 8) share all inputs.
module tb_counter_sampler;
  import counter_sampler_pkg::*;

  localparam int W  = 16;
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [W-1:0]  q    = '0;
  logic          en   = 1'b0;
  logic          snap = 1'b0;
  logic          rdy  = 1'b0;

  logic          valid_a, valid_b;
  logic [W-1:0]  value_a, value_b, delta_a, delta_b;
  logic [7:0]    seq_a, seq_b;
  logic [CW-1:0] count_a, count_b;
`ifdef SAMPLER_DROP_CNT_EN
  logic          clr = 1'b0;
  logic [15:0]   drops_a, drops_b;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  counter_sampler #(.width(W), .period(4), .depth(4)) dut_a (
    .CLK(clk), .RST(rst), .Q_IN(q), .ENABLE(en), .SNAP(snap),
    .OUT_VALID(valid_a), .OUT_READY(rdy), .OUT_VALUE(value_a),
    .OUT_DELTA(delta_a), .OUT_SEQ(seq_a),
`ifdef SAMPLER_DROP_CNT_EN
    .DROPS(drops_a), .DROPS_CLR(clr),
`endif
    .COUNT(count_a)
  );

  counter_sampler #(.width(W), .period(8), .depth(4)) dut_b (
    .CLK(clk), .RST(rst), .Q_IN(q), .ENABLE(en), .SNAP(snap),
    .OUT_VALID(valid_b), .OUT_READY(rdy), .OUT_VALUE(value_b),
    .OUT_DELTA(delta_b), .OUT_SEQ(seq_b),
`ifdef SAMPLER_DROP_CNT_EN
    .DROPS(drops_b), .DROPS_CLR(clr),
`endif
    .COUNT(count_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst  = 1'b1;
    q    = '0;
    en   = 1'b0;
    snap = 1'b0;
    rdy  = 1'b0;
`ifdef SAMPLER_DROP_CNT_EN
    clr  = 1'b0;
`endif
    tick();
    rst = 1'b0;
  endtask

  initial begin
    @(negedge clk);
    check("rst_valid", 32'(valid_a), 32'd0);
    check("rst_count", 32'(count_a), 32'd0);
    check("rst_value", 32'(value_a), 32'd0);
    check("rst_delta", 32'(delta_a), 32'd0);
    check("rst_seq",   32'(seq_a),   32'd0);
`ifdef SAMPLER_DROP_CNT_EN
    check("rst_drops", 32'(drops_a), 32'd0);
`endif

    // periodic sampling, period 4, Q ramps by 10 per cycle
    do_reset();
    en  = 1'b1;
    rdy = 1'b1;
    for (int k = 0; k < 12; k++) begin
      q = 16'(10 * (k + 1));
      tick();
      if (k % 4 == 3) begin
        check("per_valid", 32'(valid_a), 32'd1);
        check("per_value", 32'(value_a), 32'(10 * (k + 1)));
        check("per_delta", 32'(delta_a), 32'd40);
        check("per_seq",   32'(seq_a),   32'(k / 4));
        check("per_count", 32'(count_a), 32'd1);
      end else begin
        check("per_idle", 32'(valid_a), 32'd0);
      end
    end

    // modular delta across wrap
    do_reset();
    rdy  = 1'b1;
    snap = 1'b1;
    q    = 16'hFFF0;
    tick();
    check("wrap_first_delta", 32'(delta_a), 32'h0000FFF0);
    check("wrap_first_seq",   32'(seq_a),   32'd0);
    q = 16'h0010;
    tick();
    check("wrap_delta", 32'(delta_a), 32'h00000020);
    check("wrap_seq",   32'(seq_a),   32'd1);
    check("wrap_count", 32'(count_a), 32'd1);
    snap = 1'b0;
    tick();
    check("wrap_drained", 32'(valid_a), 32'd0);
    check("wrap_zero_value", 32'(value_a), 32'd0);

    // backpressure: six SNAPs into a 4-deep FIFO
    do_reset();
    snap = 1'b1;
    for (int i = 0; i < 6; i++) begin
      q = 16'(100 + i);
      tick();
      check("bp_count", 32'(count_a), 32'((i < 3) ? i + 1 : 4));
      check("bp_head_seq",   32'(seq_a),   32'd0);
      check("bp_head_value", 32'(value_a), 32'd100);
    end
    snap = 1'b0;
`ifdef SAMPLER_DROP_CNT_EN
    check("bp_drops", 32'(drops_a), 32'd2);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check("bp_drops_clr", 32'(drops_a), 32'd0);
`endif
    rdy = 1'b1;
    for (int j = 1; j <= 4; j++) begin
      tick();
      if (j < 4) begin
        check("bp_drain_seq",   32'(seq_a),   32'(j));
        check("bp_drain_value", 32'(value_a), 32'(100 + j));
        check("bp_drain_delta", 32'(delta_a), 32'd1);
      end else begin
        check("bp_drain_empty", 32'(valid_a), 32'd0);
      end
    end
    rdy  = 1'b0;
    snap = 1'b1;
    q    = 16'd200;
    tick();
    snap = 1'b0;
    check("bp_fresh_seq",   32'(seq_a),   32'd6);
    check("bp_fresh_delta", 32'(delta_a), 32'd95);

    // full FIFO with simultaneous pop and push
    do_reset();
    snap = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      q = 16'(i);
      tick();
    end
    check("fp_full", 32'(count_a), 32'd4);
    rdy = 1'b1;
    q   = 16'd5;
    tick();
    snap = 1'b0;
    rdy  = 1'b0;
    check("fp_count", 32'(count_a), 32'd4);
    check("fp_head",  32'(seq_a),   32'd1);
`ifdef SAMPLER_DROP_CNT_EN
    check("fp_no_drop", 32'(drops_a), 32'd0);
`endif
    rdy = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    rdy = 1'b0;
    check("fp_tail_seq",   32'(seq_a),   32'd4);
    check("fp_tail_value", 32'(value_a), 32'd5);
    check("fp_tail_count", 32'(count_a), 32'd1);

    // SNAP mid-period on the period-8 instance, then ENABLE gap
    do_reset();
    en  = 1'b1;
    rdy = 1'b1;
    q   = 16'd7;
    for (int i = 0; i < 5; i++) tick();
    check("mid_none", 32'(valid_b), 32'd0);
    snap = 1'b1;
    tick();
    snap = 1'b0;
    check("mid_snap_valid", 32'(valid_b), 32'd1);
    check("mid_snap_seq",   32'(seq_b),   32'd0);
    for (int i = 1; i <= 8; i++) begin
      tick();
      check("mid_restart", 32'(valid_b), 32'(i == 8));
    end
    check("mid_restart_seq", 32'(seq_b), 32'd1);
    for (int i = 1; i <= 11; i++) begin
      en = (i >= 3 && i <= 5) ? 1'b0 : 1'b1;
      tick();
      check("mid_gap", 32'(valid_b), 32'(i == 11));
    end
    check("mid_gap_seq", 32'(seq_b), 32'd2);

    // async reset between edges with three queued entries
    do_reset();
    snap = 1'b1;
    for (int i = 0; i < 3; i++) begin
      q = 16'(50 + 10 * i);
      tick();
    end
    snap = 1'b0;
    check("ar_queued", 32'(count_a), 32'd3);
    #2 rst = 1'b1;
    #1;
    check("ar_valid", 32'(valid_a), 32'd0);
    check("ar_count", 32'(count_a), 32'd0);
    check("ar_value", 32'(value_a), 32'd0);
    check("ar_delta", 32'(delta_a), 32'd0);
    check("ar_seq",   32'(seq_a),   32'd0);
    #1 rst = 1'b0;
    snap = 1'b1;
    q    = 16'd33;
    tick();
    snap = 1'b0;
    check("ar_after_seq",   32'(seq_a),   32'd0);
    check("ar_after_delta", 32'(delta_a), 32'd33);
    check("ar_after_count", 32'(count_a), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
